// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// requester count, the request record and a helper to classify requests.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;
  localparam int NUM_REQ    = 2;

  // One memory request as presented by a requester.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
  } dmem_req_t;

  // Any byte enable set means the request writes; all-zero means read.
  function automatic logic is_write(input logic [BE_W_DEF-1:0] be);
    return |be;
  endfunction

endpackage

// File: rtl/dmem_rsp_skid.sv
// Per-requester response path: tracks a read in flight, passes the
// registered memory data straight through when the requester is ready, and
// parks it in a one-entry hold register when the requester stalls.
module dmem_rsp_skid
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_read_accept,
  input  logic              i_read_req,
  input  logic              i_rsp_ready,
  input  logic [DATA_W-1:0] i_mem_q,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_blocked
);

  logic              inflight_q;
  logic              holdValid_q, holdValid_d;
  logic [DATA_W-1:0] holdData_q, holdData_d;

  // Capture the memory word when a fresh response meets a stalled consumer;
  // release the hold once the consumer takes it.
  always_comb begin
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    if (inflight_q && !i_rsp_ready) begin
      holdValid_d = 1'b1;
      holdData_d  = i_mem_q;
    end else if (holdValid_q && i_rsp_ready) begin
      holdValid_d = 1'b0;
    end
  end

  // Response state registers; reset discards anything pending or held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      inflight_q  <= 1'b0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
    end else begin
      inflight_q  <= i_read_accept;
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
    end
  end

  assign o_rsp_valid = inflight_q | holdValid_q;
  assign o_rsp_rdata = holdValid_q ? holdData_q : i_mem_q;

  // A new read must wait while an older response is still owed, unless that
  // response is being handed over in this very cycle.
  assign o_blocked = i_read_req & (inflight_q | holdValid_q)
                   & ~(o_rsp_valid & i_rsp_ready);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the CPU load/store unit
// (requester 0) and the DMA/debug master (requester 1) with round-robin
// priority, one access per cycle, and per-requester read response buffering.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_wdata,
  input  logic [NUM_REQ-1:0][BE_W-1:0]    i_req_be,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  input  logic [NUM_REQ-1:0]              i_rsp_ready,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  o_rsp_rdata,
  output logic [ADDR_W-1:0]               o_mem_address,
  output logic [DATA_W-1:0]               o_mem_data,
  output logic [BE_W-1:0]                 o_mem_wren,
  input  logic [DATA_W-1:0]               i_mem_q
);

  logic               rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] blocked;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] readAccept;
  logic [NUM_REQ-1:0] readReq;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign readReq[i]    = ~is_write(i_req_be[i]);
    assign eligible[i]   = i_req_valid[i] & ~blocked[i];
    assign readAccept[i] = grant[i] & readReq[i];

    dmem_rsp_skid #(
      .DATA_W (DATA_W)
    ) u_skid (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_read_accept (readAccept[i]),
      .i_read_req    (readReq[i]),
      .i_rsp_ready   (i_rsp_ready[i]),
      .i_mem_q       (i_mem_q),
      .o_rsp_valid   (o_rsp_valid[i]),
      .o_rsp_rdata   (o_rsp_rdata[i]),
      .o_blocked     (blocked[i])
    );
  end

  // Pick at most one eligible requester; the round-robin pointer breaks ties.
  always_comb begin
    grant = '0;
    if (!i_reset) begin
      if (&eligible) begin
        grant = rrPtr_q ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
  end

  assign o_req_ready = grant;

  // Steer the winning request onto the memory port; idle cycles read word 0.
  always_comb begin
    o_mem_address = '0;
    o_mem_data    = '0;
    o_mem_wren    = '0;
    if (grant[0]) begin
      o_mem_address = i_req_addr[0];
      o_mem_data    = i_req_wdata[0];
      o_mem_wren    = i_req_be[0];
    end else if (grant[1]) begin
      o_mem_address = i_req_addr[1];
      o_mem_data    = i_req_wdata[1];
      o_mem_wren    = i_req_be[1];
    end
  end

  // After any accept, priority passes to the requester that did not win.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (|grant) begin
      rrPtr_d = ~grant[1];
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for the data-memory port arbiter. A reference
// model predicts grants and memory drive from the arbitration rules and a
// shadow memory; predicted read data is queued per requester and a separate
// monitor compares it against the responses the design presents.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int NCYC = 4000;

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } expT;

  logic                clk;
  logic                reset;
  logic [1:0]          reqValid, reqReady, rspValid, rspReady;
  logic [1:0][AW-1:0]  reqAddr;
  logic [1:0][DW-1:0]  reqWdata, rspRdata;
  logic [1:0][3:0]     reqBe;
  logic [AW-1:0]       memAddress;
  logic [DW-1:0]       memData, memQ;
  logic [3:0]          memWren;

  int  checkCount = 0;
  int  errorCount = 0;
  int  cycle      = 0;
  bit  started    = 0;
  int  rrModel;
  expT expQ0[$];
  expT expQ1[$];

  logic [DW-1:0] envMem[0:63];
  bit   [63:0]   envWr;
  logic [DW-1:0] shadowMem[0:63];
  bit   [63:0]   shadowWr;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req_valid   (reqValid),
    .o_req_ready   (reqReady),
    .i_req_addr    (reqAddr),
    .i_req_wdata   (reqWdata),
    .i_req_be      (reqBe),
    .o_rsp_valid   (rspValid),
    .i_rsp_ready   (rspReady),
    .o_rsp_rdata   (rspRdata),
    .o_mem_address (memAddress),
    .o_mem_data    (memData),
    .o_mem_wren    (memWren),
    .i_mem_q       (memQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of a never-written word.
  function automatic logic [DW-1:0] initWord(input int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous single-port RAM driven by the design: byte-masked write,
  // registered read of the addressed word with one cycle of latency.
  always @(posedge clk) begin : envRam
    logic [DW-1:0] cur;
    int a;
    a   = int'(memAddress[5:0]);
    cur = envWr[a] ? envMem[a] : initWord(a);
    memQ <= cur;
    if (memWren != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (memWren[b]) cur[b*8 +: 8] = memData[b*8 +: 8];
      end
      envMem[a] <= cur;
      envWr[a]  <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] readShadow(input int a);
    return shadowWr[a] ? shadowMem[a] : initWord(a);
  endfunction

  // mode 0: reset held; mode 1: both requesters reading with ready high;
  // mode 2: fully random traffic with occasional reset pulses.
  task automatic applyStimulus(input int mode);
    reset = (mode == 0) || ($urandom_range(0, 199) == 0);
    for (int i = 0; i < 2; i++) begin
      reqAddr[i]  = AW'($urandom_range(0, 7));
      reqWdata[i] = $urandom;
      if (mode == 1) begin
        reqValid[i] = 1'b1;
        reqBe[i]    = 4'b0000;
        rspReady[i] = 1'b1;
      end else begin
        reqValid[i] = ($urandom_range(0, 3) != 0);
        reqBe[i]    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        rspReady[i] = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  // Head of a requester's expected-response queue is due when its data
  // became available at or before the current cycle.
  function automatic bit headDue(input int i);
    if (i == 0) return (expQ0.size() > 0) && (expQ0[0].avail <= cycle);
    return (expQ1.size() > 0) && (expQ1[0].avail <= cycle);
  endfunction

  function automatic bit owed(input int i);
    return (i == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
  endfunction

  // Stimulus and reference model: predict grant and memory drive per cycle.
  initial begin
    int mode;
    int g;
    bit [1:0] elig;
    bit [1:0] expGrant;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    logic [3:0]    expWren;
    expT e;

    reset    = 1'b1;
    reqValid = '0;
    reqAddr  = '0;
    reqWdata = '0;
    reqBe    = '0;
    rspReady = '0;
    rrModel  = 0;
    started  = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cycle++;
      mode = (c < 3) ? 0 : ((c < 200) ? 1 : 2);
      applyStimulus(mode);
      #1;
      if (reset) begin
        expQ0.delete();
        expQ1.delete();
        rrModel = 0;
        checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
        checkOutput("reset_mem_address", 32'(memAddress), 32'd0);
        checkOutput("reset_mem_data", memData, 32'd0);
        checkOutput("reset_mem_wren", 32'(memWren), 32'd0);
        continue;
      end

      for (int i = 0; i < 2; i++) begin
        bit isRead;
        bit blk;
        isRead  = (reqBe[i] == 4'b0000);
        blk     = isRead && owed(i) && !(headDue(i) && rspReady[i]);
        elig[i] = reqValid[i] && !blk;
      end

      g = -1;
      if (elig == 2'b11) g = rrModel;
      else if (elig[0])  g = 0;
      else if (elig[1])  g = 1;

      expGrant = 2'b00;
      expAddr  = '0;
      expData  = '0;
      expWren  = '0;
      if (g >= 0) begin
        expGrant[g] = 1'b1;
        expAddr     = reqAddr[g];
        expData     = reqWdata[g];
        expWren     = reqBe[g];
      end

      checkOutput("req_ready", 32'(reqReady), 32'(expGrant));
      checkOutput("mem_address", 32'(memAddress), 32'(expAddr));
      checkOutput("mem_data", memData, expData);
      checkOutput("mem_wren", 32'(memWren), 32'(expWren));

      if (g >= 0) begin
        int a;
        a       = int'(reqAddr[g][5:0]);
        rrModel = 1 - g;
        if (reqBe[g] != 4'b0000) begin
          logic [DW-1:0] w;
          w = readShadow(a);
          for (int b = 0; b < 4; b++) begin
            if (reqBe[g][b]) w[b*8 +: 8] = reqWdata[g][b*8 +: 8];
          end
          shadowMem[a] = w;
          shadowWr[a]  = 1'b1;
        end else begin
          e.data  = readShadow(a);
          e.avail = cycle + 1;
          if (g == 0) expQ0.push_back(e);
          else        expQ1.push_back(e);
        end
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Response monitor: compare presented responses against queued predictions
  // and retire an entry on each completed handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          bit due;
          due = headDue(i);
          checkOutput(i == 0 ? "rsp_valid0" : "rsp_valid1", 32'(rspValid[i]), 32'(due));
          if (due && rspValid[i]) begin
            checkOutput(i == 0 ? "rsp_rdata0" : "rsp_rdata1", rspRdata[i],
                        (i == 0) ? expQ0[0].data : expQ1[0].data);
          end
          if (due && rspReady[i]) begin
            if (i == 0) void'(expQ0.pop_front());
            else        void'(expQ1.pop_front());
          end
        end
      end
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-requester arbiter and sequencer for one port of the 64 KiB synchronous data memory (word-addressed, 14-bit index, 4-bit byte write enables, registered read with 1-cycle latency). It shares the port between requester 0 (CPU load/store unit) and requester 1 (DMA/debug master) with round-robin priority. It returns read data with valid/ready response handshakes and buffers one response per requester when that requester stalls.

Parameters:
ADDR_W, 14, word-index width (16K words)
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_req_valid  in  2  per-requester request valid
o_req_ready  out  2  per-requester request accepted this cycle when valid&ready
i_req_addr  in  2×ADDR_W  per-requester word index
i_req_wdata  in  2×DATA_W  per-requester write data
i_req_be  in  2×4  per-requester byte enables; nonzero = write, zero = read
o_rsp_valid  out  2  per-requester read response valid
i_rsp_ready  in  2  per-requester response ready
o_rsp_rdata  out  2×DATA_W  per-requester read data
o_mem_address  out  ADDR_W  to memory port address
o_mem_data  out  DATA_W  to memory port write data
o_mem_wren  out  4  to memory port byte write enables
i_mem_q  in  DATA_W  memory port registered read data

Behaviour:
- Reset (async assert): rr_ptr=0, inflight[1:0]=0, hold_valid[1:0]=0, hold_data=0. o_rsp_valid=0, o_req_ready=0, o_mem_wren=0, o_mem_address=0, o_mem_data=0.
- Eligibility: requester i is eligible when i_req_valid[i] and not blocked[i]. blocked[i] = i_req_be[i]==0 (read) and (inflight[i] or hold_valid[i]) and not (o_rsp_valid[i] & i_rsp_ready[i]). Writes are never blocked by response state.
- Arbitration (combinational): grant the eligible requester. If both are eligible, grant rr_ptr. Exactly one grant at most per cycle. o_req_ready[i] = grant[i].
- rr_ptr update: on any accept, rr_ptr <= ~granted index. Otherwise it holds.
- Memory drive (same cycle as accept T): o_mem_address/o_mem_data = granted request, o_mem_wren = granted be. With no grant, all three are 0; a no-grant cycle performs a harmless read of word 0.
- Read accepted at T: inflight[i] set at edge ending T, cleared the next edge unless re-set by a back-to-back read.
- Cycle T+1 with inflight[i]: o_rsp_valid[i]=1, o_rsp_rdata[i]=i_mem_q (pass-through, 1-cycle latency). If i_rsp_ready[i]=0, capture i_mem_q into hold_data[i] and set hold_valid[i].
- hold_valid[i]: o_rsp_valid[i]=1, o_rsp_rdata[i]=hold_data[i], stable until i_rsp_ready[i]. Then hold_valid clears. inflight and hold_valid are never both set for the same requester.
- Throughput: one access per cycle total. A single requester with rsp_ready tied high sustains back-to-back reads.
- Write followed by read of the same word by either requester in the next cycle returns the new data, since the memory is read-after-write by cycle order.
- Reset mid-operation: pending/held responses are discarded, no o_rsp_valid after release. An in-progress write completes only if its edge precedes the reset assertion.
- The arbiter never issues a write to the memory's other port. Cross-port collisions are the system's responsibility.

Decomposition:
- Package dmem_arb_pkg: ADDR_W/DATA_W defaults, NUM_REQ=2 constant, a typedef for the request struct (addr, wdata, be), and a function is_write(be).
- Sub-module dmem_rsp_skid: one instance per requester. Holds the inflight flag and the hold register, and produces rsp_valid/rdata and the blocked signal.

Test Plan:
- Single read: mem[0x0010]=0xDEADBEEF, req0 read addr 0x0010, rsp_ready=1 -> ready0 at T, rsp_valid0 at T+1 with 0xDEADBEEF, then deasserted.
- Byte write then read: req1 write addr 0x0020 be=0b0100 wdata=0x00AB0000 over 0x11223344 -> wren=0b0100 at T. A read at T+1 returns 0x11AB3344 at T+2.
- Contention: both valid every cycle with reads, rsp_ready=1 -> grants alternate 0,1,0,1 starting with requester 0 after reset. Each response is routed to the correct requester.
- Response stall: req0 read 0x0005 (0x5555AAAA), rsp_ready0=0 for 4 cycles -> rsp_valid0 held with stable 0x5555AAAA. A second req0 read is not accepted while req1 traffic proceeds. Raising rsp_ready0 clears it, and the next req0 read is accepted the same cycle.
- Back-to-back: req0 reads 0x0001,0x0002,0x0003 consecutively, req1 idle, rsp_ready=1 -> three accepts in three cycles and responses on three consecutive cycles in order.
- Reset mid-read: assert i_reset in the cycle after an accept -> o_rsp_valid=0 immediately (async), no response after release, rr_ptr=0.
